led_seq_scheduler: RTL and testbench
====================================

Name: led_seq_scheduler

Overview:
Controller that sequences a 4-LED bank through selectable light patterns at a programmable step rate.
- Owns the step timing (clock prescaler plus per-step dwell counter), pattern selection and start/stop control.
- Drives the LED outputs directly.
- Sits between the board control logic (buttons/registers) and the LED pins; replaces free-running per-clock LED stepping with a timed, controllable sequence.

Parameters:
CLK_DIV, 4, clocks per tick; legal range >= 1; CLK_DIV=1 means one tick every clock.
DWELL_W, 8, width of the dwell input and dwell counter.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  level-sampled request to begin sequencing; acted on only in IDLE
stop  in  1  request to end sequencing after the current pattern cycle completes
mode  in  2  pattern select: 0 chase, 1 bounce, 2 blink, 3 fill
dwell  in  DWELL_W  ticks per step; 0 is treated as 1
busy  out  1  high in RUN and DRAIN
step_done  out  1  one-clock pulse when a step's dwell expires
cycle_done  out  1  one-clock pulse when the last step of a pattern expires
led  out  4  LED drive, led[0] = LED1

Behaviour:
Reset values:
- State IDLE; led=0000, busy=0, step_done=0, cycle_done=0.
- Prescaler, dwell counter and step index all 0.
- rst takes effect on the next edge from any state, including mid-cycle, with no drain.

Patterns (step order):
- chase: 0001, 0010, 0100, 1000 (4 steps)
- bounce: 0001, 0010, 0100, 1000, 0100, 0010 (6 steps)
- blink: 1111, 0000 (2 steps)
- fill: 0001, 0011, 0111, 1111 (4 steps)

IDLE:
- led=0000, busy=0.
- start=1 and stop=0 at edge N:
  - Latch mode and dwell (0 becomes 1).
  - Clear prescaler, dwell counter and step index.
  - Enter RUN.
  - From N+1: led = step 0 pattern and busy=1.
- start=1 and stop=1 together: stop wins and the block stays in IDLE.

RUN:
- Prescaler counts 0..CLK_DIV-1; a tick occurs on the clock where it equals CLK_DIV-1, then it wraps to 0.
- Each tick increments the dwell counter. On the tick where dwell counter = latched dwell - 1:
  - Clear the dwell counter.
  - Pulse step_done.
  - Advance the step index; led updates on the following clock.
- Each step is therefore displayed for exactly dwell*CLK_DIV clocks.
- On the last step's expiry:
  - Step index wraps to 0.
  - cycle_done pulses in the same clock as step_done.
  - mode and dwell are re-sampled; a new value takes effect from step 0 of the next cycle.
  - mode/dwell changes mid-cycle are ignored until then.
- start while in RUN or DRAIN is ignored.
- stop=1 in RUN (a single-clock pulse suffices) moves to DRAIN on the next edge.

DRAIN:
- Sequencing continues unchanged until cycle_done.
- On the edge that produces cycle_done: state goes to IDLE and led goes to 0000 on the next clock; no mode/dwell re-sample.
- stop while already in DRAIN has no further effect.
- If stop arrives in the same clock as cycle_done in RUN, the block still moves to DRAIN and runs one more full cycle.

Width rules:
- Dwell counter is DWELL_W bits and never exceeds dwell-1.
- The prescaler width is derived from CLK_DIV; minimum 1 bit.

Optional Feature:
LED_DIM_EN
- Defined:
  - Adds input bright (2 bits).
  - A free-running 2-bit PWM counter, cleared by rst, gates the outputs: led = pattern when pwm_cnt <= bright, else 0000.
  - bright=3 gives full on; bright=0 gives on 1 of 4 clocks.
  - Step timing is unaffected.
- Not defined: bright port absent; led = pattern.

Test Plan:
1. CLK_DIV=4, dwell=2, mode=0, start pulse at clock 10:
   - led=0001 at clocks 11-18, 0010 at 19-26, 0100 at 27-34, 1000 at 35-42, then 0001 again.
   - step_done pulses at 18, 26, 34, 42; cycle_done only at 42.
2. mode=1, dwell=1, CLK_DIV=1:
   - led sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, one step per clock.
   - cycle_done every 6 clocks.
3. dwell=0, mode=2:
   - Behaves as dwell=1: 1111 for 4 clocks, 0000 for 4 clocks.
4. Running mode=0; change mode to 3 during step 1:
   - Current cycle finishes as chase.
   - Next cycle starts 0001, 0011, 0111, 1111.
5. Running mode=3; stop pulse during step 2:
   - Remaining steps complete.
   - busy drops and led=0000 the clock after cycle_done.
   - start together with stop in IDLE: stays IDLE.
6. rst asserted mid-step 2:
   - Next clock: led=0000, busy=0, no pulses.
   - A new start begins at step 0 with a fresh prescaler.

Source files
------------

// File: rtl/led_seq_if.sv
// Control/status bundle between board control logic and the LED sequencer.
// LED_DIM_EN adds the 2-bit brightness input.
interface led_seq_if #(
   parameter int DWELL_W = 8
);
   logic               start;
   logic               stop;
   logic [1:0]         mode;
   logic [DWELL_W-1:0] dwell;
`ifdef LED_DIM_EN
   logic [1:0]         bright;
`endif
   logic               busy;
   logic               step_done;
   logic               cycle_done;
   logic [3:0]         led;

`ifdef LED_DIM_EN
   modport master (output start, stop, mode, dwell, bright,
                   input  busy, step_done, cycle_done, led);
   modport slave  (input  start, stop, mode, dwell, bright,
                   output busy, step_done, cycle_done, led);
`else
   modport master (output start, stop, mode, dwell,
                   input  busy, step_done, cycle_done, led);
   modport slave  (input  start, stop, mode, dwell,
                   output busy, step_done, cycle_done, led);
`endif
endinterface

// File: rtl/led_seq_scheduler.sv
// Timed 4-LED pattern sequencer: prescaler tick, per-step dwell, start/stop/drain control.
// Optional LED_DIM_EN: PWM brightness gating of the LED outputs.
module led_seq_scheduler #(
   parameter int CLK_DIV = 4,
   parameter int DWELL_W = 8
) (
   input  logic     clk,
   input  logic     rst,
   led_seq_if.slave bus
);
   localparam int            PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

   state_e             state_q, state_d;
   logic [PW-1:0]      presc_q, presc_d;
   logic [DWELL_W-1:0] dcnt_q, dcnt_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [1:0]         mode_q, mode_d;
   logic [2:0]         step_q, step_d;

   logic               active, tick, step_end, cyc_end, go;
   logic [DWELL_W-1:0] dwell_eff;
   logic [3:0]         pat;

   function automatic logic [2:0] last_idx(input logic [1:0] m);
      logic [2:0] r;
      case (m)
         2'd0:    r = 3'd3;
         2'd1:    r = 3'd5;
         2'd2:    r = 3'd1;
         default: r = 3'd3;
      endcase
      return r;
   endfunction

   function automatic logic [3:0] pattern(input logic [1:0] m, input logic [2:0] s);
      logic [3:0] p;
      case (m)
         2'd0:    p = 4'b0001 << s;
         2'd1:    p = (s <= 3'd3) ? (4'b0001 << s) : (4'b0001 << (3'd6 - s));
         2'd2:    p = (s == 3'd0) ? 4'b1111 : 4'b0000;
         default: p = 4'b1111 >> (3'd3 - s);
      endcase
      return p;
   endfunction

   assign dwell_eff = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
   assign active    = (state_q != IDLE);
   assign tick      = active && (presc_q == PMAX);
   assign step_end  = tick && (dcnt_q == dwell_q - 1'b1);
   assign cyc_end   = step_end && (step_q == last_idx(mode_q));
   assign go        = bus.start && !bus.stop;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         presc_q <= '0;
         dcnt_q  <= '0;
         dwell_q <= DWELL_W'(1);
         mode_q  <= '0;
         step_q  <= '0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         dcnt_q  <= dcnt_d;
         dwell_q <= dwell_d;
         mode_q  <= mode_d;
         step_q  <= step_d;
      end
   end

   // A stop coinciding with cycle_done in RUN still lands in DRAIN for one more cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (go) state_d = RUN;
         RUN:     if (bus.stop) state_d = DRAIN;
         DRAIN:   if (cyc_end) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      presc_d = presc_q;
      dcnt_d  = dcnt_q;
      dwell_d = dwell_q;
      mode_d  = mode_q;
      step_d  = step_q;
      if (state_q == IDLE) begin
         if (go) begin
            mode_d  = bus.mode;
            dwell_d = dwell_eff;
            presc_d = '0;
            dcnt_d  = '0;
            step_d  = '0;
         end
      end else begin
         presc_d = tick ? '0 : presc_q + 1'b1;
         if (tick)     dcnt_d = step_end ? '0 : dcnt_q + 1'b1;
         if (step_end) step_d = cyc_end ? '0 : step_q + 1'b1;
         // mode/dwell only change on a cycle boundary, and not when draining out
         if (cyc_end && state_q == RUN) begin
            mode_d  = bus.mode;
            dwell_d = dwell_eff;
         end
      end
   end

   always_comb begin
      bus.busy       = active;
      bus.step_done  = step_end;
      bus.cycle_done = cyc_end;
      pat            = active ? pattern(mode_q, step_q) : 4'b0000;
   end

`ifdef LED_DIM_EN
   logic [1:0] pwm_q;

   always_ff @(posedge clk) begin
      if (rst) pwm_q <= '0;
      else     pwm_q <= pwm_q + 1'b1;
   end

   assign bus.led = (pwm_q <= bus.bright) ? pat : 4'b0000;
`else
   assign bus.led = pat;
`endif
endmodule

// File: tb/tb_led_seq_scheduler.sv
// Table-driven scoreboard bench for led_seq_scheduler at CLK_DIV=4 and CLK_DIV=1.
module tb_led_seq_scheduler;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   led_seq_if #(.DWELL_W(8)) if4();
   led_seq_if #(.DWELL_W(8)) if1();

   led_seq_scheduler #(.CLK_DIV(4), .DWELL_W(8)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
   led_seq_scheduler #(.CLK_DIV(1), .DWELL_W(8)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

   typedef struct {
      logic [3:0] led;
      logic       busy, sd, cd;
      string      nm;
   } exp_t;

   typedef struct {
      bit         d1;
      logic       rst, start, stop;
      logic [1:0] mode;
      logic [7:0] dwell;
      int         reps;
      logic [3:0] led;
      logic       busy, sd, cd;
      string      nm;
   } vec_t;

   exp_t q4[$];
   exp_t q1[$];
   vec_t vt[$];
   exp_t e4, e1;
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input exp_t e, input logic [3:0] led, input logic busy, sd, cd);
      n_chk++;
      if ({led, busy, sd, cd} !== {e.led, e.busy, e.sd, e.cd}) begin
         n_fail++;
         $display("FAIL %s @%0t: got led=%b busy=%b step_done=%b cycle_done=%b, want led=%b busy=%b step_done=%b cycle_done=%b",
                  e.nm, $time, led, busy, sd, cd, e.led, e.busy, e.sd, e.cd);
      end
   endtask

   // Outputs are sampled mid-period, away from the active edge.
   always @(negedge clk) begin
      if (q4.size() > 0) begin
         e4 = q4.pop_front();
         chk(e4, if4.led, if4.busy, if4.step_done, if4.cycle_done);
      end
      if (q1.size() > 0) begin
         e1 = q1.pop_front();
         chk(e1, if1.led, if1.busy, if1.step_done, if1.cycle_done);
      end
   end

   task automatic drive(input bit d1, input logic st, sp, input logic [1:0] m, input logic [7:0] dw);
      if (d1) begin
         if1.start = st; if1.stop = sp; if1.mode = m; if1.dwell = dw;
      end else begin
         if4.start = st; if4.stop = sp; if4.mode = m; if4.dwell = dw;
      end
   endtask

   // Expected outputs for the current period, then advance one clock.
   task automatic cyc(input bit d1, input logic [3:0] led, input logic busy, sd, cd, input string nm);
      exp_t e;
      e.led = led; e.busy = busy; e.sd = sd; e.cd = cd; e.nm = nm;
      if (d1) q1.push_back(e);
      else    q4.push_back(e);
      @(posedge clk);
      #1;
   endtask

   function automatic void add(input bit d1, input logic r, st, sp, input logic [1:0] m,
                               input logic [7:0] dw, input int reps, input logic [3:0] led,
                               input logic busy, sd, cd, input string nm);
      vec_t v;
      v.d1 = d1; v.rst = r; v.start = st; v.stop = sp; v.mode = m; v.dwell = dw; v.reps = reps;
      v.led = led; v.busy = busy; v.sd = sd; v.cd = cd; v.nm = nm;
      vt.push_back(v);
   endfunction

   logic [3:0] bnc [6];

   initial begin
      bnc[0] = 4'b0001; bnc[1] = 4'b0010; bnc[2] = 4'b0100;
      bnc[3] = 4'b1000; bnc[4] = 4'b0100; bnc[5] = 4'b0010;

      // reset and chase (CLK_DIV=4, dwell=2), mode->fill mid-cycle, start ignored in RUN
      add(0,1,0,0,0,2, 1, 4'b0000,0,0,0, "reset4");
      add(1,1,0,0,0,1, 1, 4'b0000,0,0,0, "reset1");
      add(0,0,0,0,0,2, 2, 4'b0000,0,0,0, "idle");
      add(0,0,1,0,0,2, 1, 4'b0000,0,0,0, "t1_start");
      add(0,0,0,0,0,2, 7, 4'b0001,1,0,0, "t1_s0");
      add(0,0,0,0,0,2, 1, 4'b0001,1,1,0, "t1_s0_end");
      add(0,0,0,0,3,2, 7, 4'b0010,1,0,0, "t1_s1_modechg");
      add(0,0,0,0,3,2, 1, 4'b0010,1,1,0, "t1_s1_end");
      add(0,0,1,0,3,2, 7, 4'b0100,1,0,0, "t1_s2_start_ign");
      add(0,0,0,0,3,2, 1, 4'b0100,1,1,0, "t1_s2_end");
      add(0,0,0,0,3,2, 7, 4'b1000,1,0,0, "t1_s3");
      add(0,0,0,0,3,2, 1, 4'b1000,1,1,1, "t1_cycle_done");
      // fill cycle with stop during step 2
      add(0,0,0,0,3,2, 7, 4'b0001,1,0,0, "t4_f0");
      add(0,0,0,0,3,2, 1, 4'b0001,1,1,0, "t4_f0_end");
      add(0,0,0,0,3,2, 7, 4'b0011,1,0,0, "t4_f1");
      add(0,0,0,0,3,2, 1, 4'b0011,1,1,0, "t4_f1_end");
      add(0,0,0,1,3,2, 1, 4'b0111,1,0,0, "t5_stop");
      add(0,0,0,0,3,2, 6, 4'b0111,1,0,0, "t5_drain_f2");
      add(0,0,0,0,3,2, 1, 4'b0111,1,1,0, "t5_f2_end");
      add(0,0,0,0,3,2, 7, 4'b1111,1,0,0, "t5_f3");
      add(0,0,0,0,3,2, 1, 4'b1111,1,1,1, "t5_drain_done");
      add(0,0,0,0,3,2, 2, 4'b0000,0,0,0, "t5_idle");
      add(0,0,1,1,3,2, 1, 4'b0000,0,0,0, "t5_start_stop");
      add(0,0,0,0,3,2, 3, 4'b0000,0,0,0, "t5_stay_idle");
      // blink with dwell=0, stop coinciding with cycle_done runs one more cycle
      add(0,0,1,0,2,0, 1, 4'b0000,0,0,0, "t3_start");
      add(0,0,0,0,2,0, 3, 4'b1111,1,0,0, "t3_on");
      add(0,0,0,0,2,0, 1, 4'b1111,1,1,0, "t3_on_end");
      add(0,0,0,0,2,0, 3, 4'b0000,1,0,0, "t3_off");
      add(0,0,0,1,2,0, 1, 4'b0000,1,1,1, "t3_stop_at_cd");
      add(0,0,0,0,2,0, 3, 4'b1111,1,0,0, "t3_extra_on");
      add(0,0,0,0,2,0, 1, 4'b1111,1,1,0, "t3_extra_on_end");
      add(0,0,0,0,2,0, 3, 4'b0000,1,0,0, "t3_extra_off");
      add(0,0,0,0,2,0, 1, 4'b0000,1,1,1, "t3_extra_cd");
      add(0,0,0,0,2,0, 2, 4'b0000,0,0,0, "t3_idle");
      // bounce at CLK_DIV=1, dwell change mid-cycle takes effect next cycle
      add(1,0,1,0,1,1, 1, 4'b0000,0,0,0, "t2_start");
      for (int k = 0; k < 6; k++)
         add(1,0,0,0,1,1, 1, bnc[k],1,1,(k == 5), "t2_c1");
      for (int k = 0; k < 6; k++)
         add(1,0,0,0,1,(k >= 2) ? 8'd3 : 8'd1, 1, bnc[k],1,1,(k == 5), "t2_c2_dwellchg");
      for (int k = 0; k < 6; k++) begin
         add(1,0,0,(k == 1),1,3, 1, bnc[k],1,0,0, "t2_c3_a");
         add(1,0,0,0,1,3, 1, bnc[k],1,0,0, "t2_c3_b");
         add(1,0,0,0,1,3, 1, bnc[k],1,1,(k == 5), "t2_c3_end");
      end
      add(1,0,0,0,1,3, 2, 4'b0000,0,0,0, "t2_idle");

      rst = 1'b1;
      drive(0, 0, 0, 2'd0, 8'd2);
      drive(1, 0, 0, 2'd0, 8'd1);
`ifdef LED_DIM_EN
      if4.bright = 2'd3;
      if1.bright = 2'd3;
`endif
      repeat (2) @(posedge clk);
      #1;

      foreach (vt[i]) begin
         rst = vt[i].rst;
         drive(vt[i].d1, vt[i].start, vt[i].stop, vt[i].mode, vt[i].dwell);
         repeat (vt[i].reps) cyc(vt[i].d1, vt[i].led, vt[i].busy, vt[i].sd, vt[i].cd, vt[i].nm);
      end

      // reset in the middle of step 2, then a clean restart
      drive(0, 1, 0, 2'd0, 8'd2);
      cyc(0, 4'b0000,0,0,0, "t6_start");
      drive(0, 0, 0, 2'd0, 8'd2);
      repeat (7) cyc(0, 4'b0001,1,0,0, "t6_s0");
      cyc(0, 4'b0001,1,1,0, "t6_s0_end");
      repeat (7) cyc(0, 4'b0010,1,0,0, "t6_s1");
      cyc(0, 4'b0010,1,1,0, "t6_s1_end");
      repeat (2) cyc(0, 4'b0100,1,0,0, "t6_s2");
      rst = 1'b1;
      cyc(0, 4'b0100,1,0,0, "t6_pre_rst");
      rst = 1'b0;
      cyc(0, 4'b0000,0,0,0, "t6_rst_clear");
      drive(0, 1, 0, 2'd0, 8'd2);
      cyc(0, 4'b0000,0,0,0, "t6_restart");
      drive(0, 0, 0, 2'd0, 8'd2);
      repeat (7) cyc(0, 4'b0001,1,0,0, "t6_fresh_s0");
      cyc(0, 4'b0001,1,1,0, "t6_fresh_s0_end");
      cyc(0, 4'b0010,1,0,0, "t6_fresh_s1");

      n_chk++;
      if (q4.size() + q1.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", q4.size() + q1.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
